key_press_decoder: RTL and testbench

//  Consumes the debounced event pair (key_flag, key_state) from one key_filter instance
//  and classifies each key gesture as a short press, a double press or a long press.

---
 rtl/key_press_decoder_if.sv | 28 ++
 rtl/key_press_decoder.sv | 111 +++++++++++
 tb/tb_key_press_decoder.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/key_press_decoder_if.sv
// Event/gesture bundle between one key_filter output pair and its key_press_decoder.
// The master drives the debounced key events; the slave returns gesture pulses and busy.
interface key_press_decoder_if;
  logic key_flag;
  logic key_state;
  logic short_press;
  logic double_press;
  logic long_press;
  logic busy;

  modport master (
    output key_flag,
    output key_state,
    input  short_press,
    input  double_press,
    input  long_press,
    input  busy
  );

  modport slave (
    input  key_flag,
    input  key_state,
    output short_press,
    output double_press,
    output long_press,
    output busy
  );
endinterface

// File: rtl/key_press_decoder.sv
// Classifies debounced key gestures into one-cycle short/double/long press pulses.
// One instance per key, fed by key_filter's (key_flag, key_state) pair.
module key_press_decoder #(
  parameter int LONG_CNT = 50_000_000,
  parameter int DCLK_CNT = 15_000_000,
  parameter int CNT_W    = 26
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  key_press_decoder_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE,
    PRESSED1,
    WAIT2,
    PRESSED2,
    LHOLD
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] DCLK_LAST = CNT_W'(DCLK_CNT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_short;
  logic             r_double;
  logic             r_long;
  logic             w_short;
  logic             w_double;
  logic             w_long;
  logic             w_press;
  logic             w_release;
  logic             w_counting;

  assign w_press    = bus.key_flag & ~bus.key_state;
  assign w_release  = bus.key_flag &  bus.key_state;
  assign w_counting = (r_state == PRESSED1) || (r_state == WAIT2) || (r_state == PRESSED2);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_short  <= 1'b0;
      r_double <= 1'b0;
      r_long   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_short  <= w_short;
      r_double <= w_double;
      r_long   <= w_long;
      if (w_next != r_state)
        r_cnt <= '0;
      else if (w_counting && (r_cnt != {CNT_W{1'b1}}))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  // Events are tested before counter expiry so an edge on the last cycle still wins.
  always_comb begin
    w_next   = r_state;
    w_short  = 1'b0;
    w_double = 1'b0;
    w_long   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_press)
          w_next = PRESSED1;
      end
      PRESSED1: begin
        if (w_release) begin
          w_next = WAIT2;
        end else if (r_cnt == LONG_LAST) begin
          w_next = LHOLD;
          w_long = 1'b1;
        end
      end
      WAIT2: begin
        if (w_press) begin
          w_next = PRESSED2;
        end else if (r_cnt == DCLK_LAST) begin
          w_next  = IDLE;
          w_short = 1'b1;
        end
      end
      PRESSED2: begin
        if (w_release) begin
          w_next   = IDLE;
          w_double = 1'b1;
        end else if (r_cnt == LONG_LAST) begin
          w_next = LHOLD;
          w_long = 1'b1;
        end
      end
      LHOLD: begin
        if (w_release)
          w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign bus.short_press  = r_short;
  assign bus.double_press = r_double;
  assign bus.long_press   = r_long;
  assign bus.busy         = (r_state != IDLE);

endmodule

// File: tb/tb_key_press_decoder.sv
// Directed bench for key_press_decoder with LONG_CNT=20, DCLK_CNT=10.
// Each row drives one cycle of key events and gives the outputs expected just after that edge.
module tb_key_press_decoder;

  localparam int LONG_CNT = 20;
  localparam int DCLK_CNT = 10;
  localparam int CNT_W    = 5;

  // Expected output nibble order: {short_press, double_press, long_press, busy}
  localparam logic [3:0] Z = 4'b0000;
  localparam logic [3:0] B = 4'b0001;
  localparam logic [3:0] S = 4'b1000;
  localparam logic [3:0] D = 4'b0100;
  localparam logic [3:0] L = 4'b0011;

  typedef struct {
    string      name;
    logic       kf;
    logic       ks;
    logic [3:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   vecCount  = 0;
  int   missCount = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  key_press_decoder_if bus ();

  key_press_decoder #(
    .LONG_CNT (LONG_CNT),
    .DCLK_CNT (DCLK_CNT),
    .CNT_W    (CNT_W)
  ) dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (bus)
  );

  task automatic addRows(input string name, input int n, input logic kf, input logic ks,
                         input logic [3:0] exp);
    vec_t v;
    v.name = name;
    v.kf   = kf;
    v.ks   = ks;
    v.exp  = exp;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic kf, input logic ks);
    bus.key_flag  = kf;
    bus.key_state = ks;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] exp);
    logic [3:0] act;
    act = {bus.short_press, bus.double_press, bus.long_press, bus.busy};
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got sdlb=%b expected sdlb=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input string name, input logic kf, input logic ks, input logic [3:0] exp);
    applyStimulus(kf, ks);
    checkOutput(name, exp);
  endtask

  initial begin
    // 1: short press, short_press 10 cycles after the release flag
    addRows("s1 press",   1, 1'b1, 1'b0, B);
    addRows("s1 hold",    4, 1'b0, 1'b0, B);
    addRows("s1 release", 1, 1'b1, 1'b1, B);
    addRows("s1 wait",    9, 1'b0, 1'b1, B);
    addRows("s1 short",   1, 1'b0, 1'b1, S);
    addRows("s1 idle",    5, 1'b0, 1'b1, Z);
    // 2: double press
    addRows("s2 press1",   1, 1'b1, 1'b0, B);
    addRows("s2 hold1",    4, 1'b0, 1'b0, B);
    addRows("s2 release1", 1, 1'b1, 1'b1, B);
    addRows("s2 gap",      3, 1'b0, 1'b1, B);
    addRows("s2 press2",   1, 1'b1, 1'b0, B);
    addRows("s2 hold2",    2, 1'b0, 1'b0, B);
    addRows("s2 release2", 1, 1'b1, 1'b1, D);
    addRows("s2 idle",    12, 1'b0, 1'b1, Z);
    // 3: long press, stray press in LHOLD, silent release
    addRows("s3 press",     1, 1'b1, 1'b0, B);
    addRows("s3 hold",     19, 1'b0, 1'b0, B);
    addRows("s3 long",      1, 1'b0, 1'b0, L);
    addRows("s3 lhold",     4, 1'b0, 1'b0, B);
    addRows("s3 lhold prs", 1, 1'b1, 1'b0, B);
    addRows("s3 lhold2",    5, 1'b0, 1'b0, B);
    addRows("s3 release",   1, 1'b1, 1'b1, Z);
    addRows("s3 idle",     12, 1'b0, 1'b1, Z);
    // 6: stray releases in IDLE, repeated press in PRESSED1, stray release in WAIT2
    addRows("s6 idle rel",  1, 1'b1, 1'b1, Z);
    addRows("s6 idle",      2, 1'b0, 1'b1, Z);
    addRows("s6 idle rel2", 1, 1'b1, 1'b1, Z);
    addRows("s6 press",     1, 1'b1, 1'b0, B);
    addRows("s6 re-press",  1, 1'b1, 1'b0, B);
    addRows("s6 hold",      1, 1'b0, 1'b0, B);
    addRows("s6 re-press2", 1, 1'b1, 1'b0, B);
    addRows("s6 release",   1, 1'b1, 1'b1, B);
    addRows("s6 wait",      1, 1'b0, 1'b1, B);
    addRows("s6 wait rel",  1, 1'b1, 1'b1, B);
    addRows("s6 wait2",     7, 1'b0, 1'b1, B);
    addRows("s6 short",     1, 1'b0, 1'b1, S);
    addRows("s6 idle end",  3, 1'b0, 1'b1, Z);

    rst_n         = 1'b0;
    bus.key_flag  = 1'b0;
    bus.key_state = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset state", Z);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].kf, vecs[i].ks);
      checkOutput(vecs[i].name, vecs[i].exp);
    end

    // 4a: press lands exactly when WAIT2 cnt==9 -> double path, no short_press
    step("s4a press1", 1'b1, 1'b0, B);
    repeat (2) step("s4a hold1", 1'b0, 1'b0, B);
    step("s4a release1", 1'b1, 1'b1, B);
    repeat (9) step("s4a wait", 1'b0, 1'b1, B);
    step("s4a press2 at expiry", 1'b1, 1'b0, B);
    step("s4a hold2", 1'b0, 1'b0, B);
    step("s4a release2", 1'b1, 1'b1, D);
    repeat (3) step("s4a idle", 1'b0, 1'b1, Z);

    // 4b: release lands exactly when PRESSED1 cnt==19 -> no long_press, then short
    step("s4b press", 1'b1, 1'b0, B);
    repeat (19) step("s4b hold", 1'b0, 1'b0, B);
    step("s4b release at expiry", 1'b1, 1'b1, B);
    repeat (9) step("s4b wait", 1'b0, 1'b1, B);
    step("s4b short", 1'b0, 1'b1, S);
    step("s4b idle", 1'b0, 1'b1, Z);

    // 5: asynchronous reset mid-press abandons the gesture
    step("s5 press", 1'b1, 1'b0, B);
    repeat (10) step("s5 hold", 1'b0, 1'b0, B);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("s5 async reset", Z);
    repeat (2) begin
      @(posedge clk);
      #1;
      checkOutput("s5 in reset", Z);
    end
    rst_n = 1'b1;
    step("s5 release after reset", 1'b1, 1'b1, Z);
    repeat (25) step("s5 idle", 1'b0, 1'b1, Z);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
